// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the CPU/DMA unified-memory arbiter.
package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned CNT_W      = 4;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select for the memory arbiter.
// ARB_RR_EN defined: round-robin on ties; otherwise fixed CPU priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic cpu_req,
  input  logic dma_req,
  input  logic last_owner,
  output logic gnt_valid_c,
  output logic gnt_owner_c
);

  assign gnt_valid_c = cpu_req | dma_req;

`ifdef ARB_RR_EN
  // On a tie the port that did not win last time goes first.
  always_comb begin
    gnt_owner_c = OWN_CPU;
    if (cpu_req && dma_req) begin
      gnt_owner_c = (last_owner == OWN_CPU) ? OWN_DMA : OWN_CPU;
    end else if (dma_req) begin
      gnt_owner_c = OWN_DMA;
    end
  end
`else
  logic last_owner_unused;
  assign last_owner_unused = last_owner;

  assign gnt_owner_c = (!cpu_req && dma_req) ? OWN_DMA : OWN_CPU;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (CPU/DMA) arbiter for a single fixed-latency memory port.
// Tie-break policy selected by ARB_RR_EN (round-robin) vs fixed CPU priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              cpuReq,
  input  logic              cpuWe,
  input  logic [ADDR_W-1:0] cpuAdr,
  input  logic [DATA_W-1:0] cpuWriteData,
  output logic              cpuAck,
  output logic [DATA_W-1:0] cpuReadData,
  input  logic              dmaReq,
  input  logic              dmaWe,
  input  logic [ADDR_W-1:0] dmaAdr,
  input  logic [DATA_W-1:0] dmaWriteData,
  output logic              dmaAck,
  output logic [DATA_W-1:0] dmaReadData,
  output logic [ADDR_W-1:0] memAdr,
  output logic [DATA_W-1:0] memWriteData,
  output logic              memWrite,
  input  logic [DATA_W-1:0] memReadData,
  output logic              busy,
  output logic              owner
);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_owner_q, last_owner_d;
  logic             we_q, we_d;
  logic             owner_d, busy_d;
  logic             mem_write_d, cpu_ack_d, dma_ack_d;
  logic [ADDR_W-1:0] adr_d;
  logic [DATA_W-1:0] wdata_d, cpu_rdata_d, dma_rdata_d;
  logic             gnt_valid_c, gnt_owner_c;

  mem_arb_pick u_pick (
    .cpu_req     (cpuReq),
    .dma_req     (dmaReq),
    .last_owner  (last_owner_q),
    .gnt_valid_c (gnt_valid_c),
    .gnt_owner_c (gnt_owner_c)
  );

  // Next-state and next-output logic; every output is a register below.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    owner_d      = owner;
    busy_d       = busy;
    adr_d        = memAdr;
    wdata_d      = memWriteData;
    mem_write_d  = 1'b0;
    cpu_ack_d    = 1'b0;
    dma_ack_d    = 1'b0;
    cpu_rdata_d  = cpuReadData;
    dma_rdata_d  = dmaReadData;

    case (state_q)
      IDLE: begin
        if (gnt_valid_c) begin
          state_d      = ACCESS;
          cnt_d        = CNT_W'(MEM_LAT);
          owner_d      = gnt_owner_c;
          last_owner_d = gnt_owner_c;
          busy_d       = 1'b1;
          if (gnt_owner_c == OWN_DMA) begin
            we_d        = dmaWe;
            adr_d       = dmaAdr;
            wdata_d     = dmaWriteData;
            mem_write_d = dmaWe;
          end else begin
            we_d        = cpuWe;
            adr_d       = cpuAdr;
            wdata_d     = cpuWriteData;
            mem_write_d = cpuWe;
          end
        end
      end

      ACCESS: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Last access cycle: read data is valid now, ack goes out next cycle.
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
          if (owner == OWN_DMA) begin
            dma_ack_d = 1'b1;
            if (!we_q) dma_rdata_d = memReadData;
          end else begin
            cpu_ack_d = 1'b1;
            if (!we_q) cpu_rdata_d = memReadData;
          end
        end
      end

      RESP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_owner_q <= OWN_DMA;
      we_q         <= 1'b0;
      owner        <= OWN_CPU;
      busy         <= 1'b0;
      memAdr       <= '0;
      memWriteData <= '0;
      memWrite     <= 1'b0;
      cpuAck       <= 1'b0;
      dmaAck       <= 1'b0;
      cpuReadData  <= '0;
      dmaReadData  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      owner        <= owner_d;
      busy         <= busy_d;
      memAdr       <= adr_d;
      memWriteData <= wdata_d;
      memWrite     <= mem_write_d;
      cpuAck       <= cpu_ack_d;
      dmaAck       <= dma_ack_d;
      cpuReadData  <= cpu_rdata_d;
      dmaReadData  <= dma_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction table, arbitration and reset sequences.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned LAT = 3;

  logic          clk = 1'b0;
  logic          rstN;
  logic          cpuReq, cpuWe, dmaReq, dmaWe;
  logic [AW-1:0] cpuAdr, dmaAdr, memAdr;
  logic [DW-1:0] cpuWriteData, dmaWriteData, cpuReadData, dmaReadData;
  logic [DW-1:0] memWriteData, memReadData;
  logic          cpuAck, dmaAck, memWrite, busy, owner;

  int checks = 0;
  int errors = 0;

  logic [31:0] cpu_q[$];
  logic [31:0] dma_q[$];
  logic [31:0] mon_exp;

  logic [31:0] wmem[256];
  bit          written[256];

  typedef struct {
    logic        dma;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[9];

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk          (clk),
    .rstN         (rstN),
    .cpuReq       (cpuReq),
    .cpuWe        (cpuWe),
    .cpuAdr       (cpuAdr),
    .cpuWriteData (cpuWriteData),
    .cpuAck       (cpuAck),
    .cpuReadData  (cpuReadData),
    .dmaReq       (dmaReq),
    .dmaWe        (dmaWe),
    .dmaAdr       (dmaAdr),
    .dmaWriteData (dmaWriteData),
    .dmaAck       (dmaAck),
    .dmaReadData  (dmaReadData),
    .memAdr       (memAdr),
    .memWriteData (memWriteData),
    .memWrite     (memWrite),
    .memReadData  (memReadData),
    .busy         (busy),
    .owner        (owner)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input logic [7:0] a);
    case (a)
      8'h10:   return 32'hDEADBEEF;
      8'h20:   return 32'hA5A5A5A5;
      default: return 32'hC0DE0000 | {24'h0, a};
    endcase
  endfunction

  // Memory model: preset contents until the arbiter writes a location.
  assign memReadData = written[memAdr[7:0]] ? wmem[memAdr[7:0]] : init_val(memAdr[7:0]);

  always @(posedge clk) begin
    if (memWrite) begin
      wmem[memAdr[7:0]]    <= memWriteData;
      written[memAdr[7:0]] <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: each ack pops the expected read data for its port.
  always @(negedge clk) begin
    if (rstN) begin
      chk("dual_ack", 32'(cpuAck & dmaAck), 32'h0);
      if (cpuAck) begin
        if (cpu_q.size() == 0) chk("cpu_ack_unexpected", 32'(cpuAck), 32'h0);
        else begin
          mon_exp = cpu_q.pop_front();
          chk("cpu_rdata", cpuReadData, mon_exp);
        end
      end
      if (dmaAck) begin
        if (dma_q.size() == 0) chk("dma_ack_unexpected", 32'(dmaAck), 32'h0);
        else begin
          mon_exp = dma_q.pop_front();
          chk("dma_rdata", dmaReadData, mon_exp);
        end
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_memAdr"},   memAdr, 32'h0);
    chk({tag, "_memWdata"}, memWriteData, 32'h0);
    chk({tag, "_memWrite"}, 32'(memWrite), 32'h0);
    chk({tag, "_cpuAck"},   32'(cpuAck), 32'h0);
    chk({tag, "_dmaAck"},   32'(dmaAck), 32'h0);
    chk({tag, "_cpuRd"},    cpuReadData, 32'h0);
    chk({tag, "_dmaRd"},    dmaReadData, 32'h0);
    chk({tag, "_busy"},     32'(busy), 32'h0);
    chk({tag, "_owner"},    32'(owner), 32'h0);
  endtask

  task automatic idle_inputs();
    cpuReq = 1'b0; cpuWe = 1'b0; cpuAdr = '0; cpuWriteData = '0;
    dmaReq = 1'b0; dmaWe = 1'b0; dmaAdr = '0; dmaWriteData = '0;
  endtask

  task automatic do_reset();
    rstN = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk) rstN = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One isolated transaction: checks the access window, ack latency and pulse width.
  task automatic do_txn(input string tag, input logic p, input logic we,
                        input logic [31:0] adr, input logic [31:0] wd, input logic [31:0] exp);
    int ack_at;
    ack_at = 0;
    if (p) begin
      dma_q.push_back(exp);
      dmaReq = 1'b1; dmaWe = we; dmaAdr = adr; dmaWriteData = wd;
    end else begin
      cpu_q.push_back(exp);
      cpuReq = 1'b1; cpuWe = we; cpuAdr = adr; cpuWriteData = wd;
    end
    @(posedge clk);
    for (int c = 1; c <= int'(LAT) + 4 && ack_at == 0; c++) begin
      @(negedge clk);
      if (c <= int'(LAT)) begin
        chk({tag, "_busy"},   32'(busy), 32'h1);
        chk({tag, "_owner"},  32'(owner), 32'(p));
        chk({tag, "_memAdr"}, memAdr, adr);
        chk({tag, "_memWd"},  memWriteData, wd);
        chk({tag, "_memWr"},  32'(memWrite), 32'(we && c == 1));
      end
      if (p ? dmaAck : cpuAck) begin
        ack_at = c;
        cpuReq = 1'b0; dmaReq = 1'b0;
      end
    end
    cpuReq = 1'b0; dmaReq = 1'b0;
    chk({tag, "_ack_lat"}, 32'(ack_at), 32'(LAT + 1));
    @(negedge clk);
    chk({tag, "_idle_busy"}, 32'(busy), 32'h0);
    chk({tag, "_ack_pulse"}, 32'(cpuAck | dmaAck), 32'h0);
    @(posedge clk);
    #1;
  endtask

  // Both ports request continuously from reset.
  task automatic fairness_test();
    logic ord[8];
    logic exp_ord[8];
    int   at[8];
    int   got, n;
    got = 0;
`ifdef ARB_RR_EN
    n = 4;
    exp_ord[0] = 1'b0; exp_ord[1] = 1'b1; exp_ord[2] = 1'b0; exp_ord[3] = 1'b1;
    repeat (2) cpu_q.push_back(32'h11112222);
    repeat (2) dma_q.push_back(32'hC0DE0030);
`else
    n = 5;
    exp_ord[0] = 1'b0; exp_ord[1] = 1'b0; exp_ord[2] = 1'b0; exp_ord[3] = 1'b0; exp_ord[4] = 1'b1;
    repeat (4) cpu_q.push_back(32'h11112222);
    dma_q.push_back(32'hC0DE0030);
`endif
    cpuReq = 1'b1; cpuWe = 1'b0; cpuAdr = 32'h20;
    dmaReq = 1'b1; dmaWe = 1'b0; dmaAdr = 32'h30;
    for (int c = 0; c < 200 && got < n; c++) begin
      @(negedge clk);
      if (cpuAck || dmaAck) begin
        ord[got] = dmaAck;
        at[got]  = c;
        got++;
        if (got == 4) cpuReq = 1'b0;
        if (got == n) dmaReq = 1'b0;
      end
    end
    cpuReq = 1'b0; dmaReq = 1'b0;
    chk("fair_count", 32'(got), 32'(n));
    for (int i = 0; i < got; i++) begin
      chk($sformatf("fair_owner%0d", i), 32'(ord[i]), 32'(exp_ord[i]));
      if (i > 0) chk($sformatf("fair_gap%0d", i), 32'(at[i] - at[i-1]), 32'(LAT + 2));
    end
    repeat (LAT + 4) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // CPU drops its request mid-access; a DMA request raised meanwhile is served next.
  task automatic drop_test();
    int cpu_acks, cpu_at, dma_at;
    cpu_acks = 0; cpu_at = 0; dma_at = 0;
    cpu_q.push_back(32'hDEADBEEF);
    dma_q.push_back(32'hC0DE0003);
    cpuReq = 1'b1; cpuWe = 1'b0; cpuAdr = 32'h10;
    @(posedge clk);
    @(negedge clk);
    cpuReq = 1'b0;
    dmaReq = 1'b1; dmaWe = 1'b0; dmaAdr = 32'h03;
    for (int c = 2; c <= 2 * int'(LAT) + 8; c++) begin
      @(negedge clk);
      if (cpuAck) begin cpu_acks++; cpu_at = c; end
      if (dmaAck) begin dma_at = c; dmaReq = 1'b0; end
    end
    dmaReq = 1'b0;
    chk("drop_cpu_acks", 32'(cpu_acks), 32'h1);
    chk("drop_cpu_at",   32'(cpu_at), 32'(LAT + 1));
    chk("drop_dma_at",   32'(dma_at), 32'(2 * LAT + 3));
    @(posedge clk);
    #1;
  endtask

  // Reset asserted in the second access cycle aborts without an ack.
  task automatic reset_mid_test();
    int acks;
    acks = 0;
    cpuReq = 1'b1; cpuWe = 1'b0; cpuAdr = 32'h20;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("rstmid_busy_before", 32'(busy), 32'h1);
    rstN = 1'b0;
    #1;
    chk_all_zero("rstmid");
    cpuReq = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rstN = 1'b1;
    for (int c = 0; c < int'(LAT) + 4; c++) begin
      @(negedge clk);
      if (cpuAck || dmaAck) acks++;
    end
    chk("rstmid_no_ack", 32'(acks), 32'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b0, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF};
    tbl[1] = '{1'b1, 1'b1, 32'h40, 32'h12345678, 32'h00000000};
    tbl[2] = '{1'b1, 1'b0, 32'h40, 32'h0,        32'h12345678};
    tbl[3] = '{1'b0, 1'b0, 32'h20, 32'h0,        32'hA5A5A5A5};
    tbl[4] = '{1'b0, 1'b1, 32'h20, 32'h11112222, 32'hA5A5A5A5};
    tbl[5] = '{1'b0, 1'b0, 32'h20, 32'h0,        32'h11112222};
    tbl[6] = '{1'b1, 1'b0, 32'h03, 32'h0,        32'hC0DE0003};
    tbl[7] = '{1'b1, 1'b1, 32'h00, 32'hFFFFFFFF, 32'hC0DE0003};
    tbl[8] = '{1'b0, 1'b0, 32'h00, 32'h0,        32'hFFFFFFFF};

    rstN = 1'b0;
    idle_inputs();
    #1;
    chk_all_zero("reset");
    do_reset();

    foreach (tbl[i])
      do_txn($sformatf("t%0d", i), tbl[i].dma, tbl[i].we, tbl[i].adr, tbl[i].wd, tbl[i].exp);

    do_reset();
    fairness_test();
    drop_test();
    reset_mid_test();
    do_txn("reissue", 1'b0, 1'b0, 32'h20, 32'h0, 32'h11112222);

    chk("cpu_q_drained", 32'(cpu_q.size()), 32'h0);
    chk("dma_q_drained", 32'(dma_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
